// File: rtl/mag_cmp_pkg.sv
// Shared encodings and default sizes for the magnitude-comparison tracker.
// The outcome codes double as indices into the per-outcome counter array.
package mag_cmp_pkg;

    localparam int DEF_WIDTH = 2;
    localparam int DEF_CNT_W = 8;

    localparam logic [1:0] CMP_GT = 2'd0;
    localparam logic [1:0] CMP_EQ = 2'd1;
    localparam logic [1:0] CMP_LT = 2'd2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_e;

    function automatic logic [1:0] cmp_encode(input logic gt, input logic eq, input logic lt);
        logic [1:0] code;
        case ({gt, eq, lt})
            3'b100:  code = CMP_GT;
            3'b010:  code = CMP_EQ;
            default: code = CMP_LT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mag_cmp_tracker_cmp_core.sv
// Purely combinational unsigned magnitude comparator.
// Exactly one of gt/eq/lt is high for any pair of operands.
module cmp_core #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/mag_cmp_tracker.sv
// Result collector behind a magnitude comparator: one-deep registered output
// stage with valid/ready handshake, saturating outcome counters and running extremes.
module mag_cmp_tracker
    import mag_cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_gt,
    output logic             out_eq,
    output logic             out_lt,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] run_max,
    output logic [WIDTH-1:0] run_min,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_lt
);

    logic             cmp_gt, cmp_eq, cmp_lt;
    logic [1:0]       res_code;
    logic [WIDTH-1:0] pair_max, pair_min;
    logic             accept;

    ostate_e          state_q, state_d;
    logic             gt_q, eq_q, lt_q, gt_d, eq_d, lt_d;
    logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
    logic [WIDTH-1:0] run_max_q, run_max_d, run_min_q, run_min_d;
    logic [CNT_W-1:0] cnt_arr [3];

    cmp_core #(.WIDTH(WIDTH)) u_cmp (
        .a  (in_a),
        .b  (in_b),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    assign res_code = cmp_encode(cmp_gt, cmp_eq, cmp_lt);
    assign pair_max = cmp_gt ? in_a : in_b;
    assign pair_min = cmp_gt ? in_b : in_a;
    assign accept   = in_valid && in_ready;

    // Output-stage FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Output-stage FSM: next state (clear wins over everything)
    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = ST_EMPTY;
        else if (accept)
            state_d = ST_FULL;
        else if (state_q == ST_FULL && out_ready)
            state_d = ST_EMPTY;
    end

    // Output-stage FSM: outputs; flags are masked while nothing is held
    always_comb begin
        out_valid = (state_q == ST_FULL);
        in_ready  = !clear && ((state_q == ST_EMPTY) || out_ready);
        out_gt    = out_valid && gt_q;
        out_eq    = out_valid && eq_q;
        out_lt    = out_valid && lt_q;
    end

    always_comb begin
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        max_d     = max_q;
        min_d     = min_q;
        run_max_d = run_max_q;
        run_min_d = run_min_q;
        if (clear) begin
            run_max_d = '0;
            run_min_d = '1;
        end else if (accept) begin
            gt_d      = cmp_gt;
            eq_d      = cmp_eq;
            lt_d      = cmp_lt;
            max_d     = pair_max;
            min_d     = pair_min;
            run_max_d = (pair_max > run_max_q) ? pair_max : run_max_q;
            run_min_d = (pair_min < run_min_q) ? pair_min : run_min_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            max_q     <= '0;
            min_q     <= '0;
            run_max_q <= '0;
            run_min_q <= '1;
        end else begin
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            max_q     <= max_d;
            min_q     <= min_d;
            run_max_q <= run_max_d;
            run_min_q <= run_min_d;
        end
    end

    // One saturating counter per outcome, indexed by the outcome code
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] c_q, c_d;

        always_comb begin
            c_d = c_q;
            if (clear)
                c_d = '0;
            else if (accept && res_code == 2'(gi) && c_q != {CNT_W{1'b1}})
                c_d = c_q + CNT_W'(1);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) c_q <= '0;
            else     c_q <= c_d;
        end

        assign cnt_arr[gi] = c_q;
    end

    assign out_max = max_q;
    assign out_min = min_q;
    assign run_max = run_max_q;
    assign run_min = run_min_q;
    assign cnt_gt  = cnt_arr[CMP_GT];
    assign cnt_eq  = cnt_arr[CMP_EQ];
    assign cnt_lt  = cnt_arr[CMP_LT];

endmodule

// File: tb/tb_mag_cmp_tracker.sv
// Bench for mag_cmp_tracker: scoreboard of expected results on the main 2-bit
// instance, plus a CNT_W=2 instance for saturation and a WIDTH=4 instance.
module tb_mag_cmp_tracker;

    typedef struct packed {
        logic       gt;
        logic       eq;
        logic       lt;
        logic [1:0] mx;
        logic [1:0] mn;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // main instance, WIDTH=2 CNT_W=8
    logic       clear = 0, in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [1:0] in_a = 0, in_b = 0, out_max, out_min, run_max, run_min;
    logic       out_gt, out_eq, out_lt;
    logic [7:0] cnt_gt, cnt_eq, cnt_lt;

    // saturation instance, WIDTH=2 CNT_W=2
    logic       s_clear = 0, s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0;
    logic [1:0] s_in_a = 0, s_in_b = 0, s_out_max, s_out_min, s_run_max, s_run_min;
    logic       s_out_gt, s_out_eq, s_out_lt;
    logic [1:0] s_cnt_gt, s_cnt_eq, s_cnt_lt;

    // wide instance, WIDTH=4 CNT_W=8
    logic       w_clear = 0, w_in_valid = 0, w_in_ready, w_out_valid, w_out_ready = 0;
    logic [3:0] w_in_a = 0, w_in_b = 0, w_out_max, w_out_min, w_run_max, w_run_min;
    logic       w_out_gt, w_out_eq, w_out_lt;
    logic [7:0] w_cnt_gt, w_cnt_eq, w_cnt_lt;

    mag_cmp_tracker #(.WIDTH(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_gt(out_gt), .out_eq(out_eq), .out_lt(out_lt), .out_max(out_max), .out_min(out_min),
        .run_max(run_max), .run_min(run_min), .cnt_gt(cnt_gt), .cnt_eq(cnt_eq), .cnt_lt(cnt_lt)
    );

    mag_cmp_tracker #(.WIDTH(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_gt(s_out_gt), .out_eq(s_out_eq), .out_lt(s_out_lt), .out_max(s_out_max), .out_min(s_out_min),
        .run_max(s_run_max), .run_min(s_run_min), .cnt_gt(s_cnt_gt), .cnt_eq(s_cnt_eq), .cnt_lt(s_cnt_lt)
    );

    mag_cmp_tracker #(.WIDTH(4), .CNT_W(8)) dut_w4 (
        .clk(clk), .rst(rst), .clear(w_clear), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_gt(w_out_gt), .out_eq(w_out_eq), .out_lt(w_out_lt), .out_max(w_out_max), .out_min(w_out_min),
        .run_max(w_run_max), .run_min(w_run_min), .cnt_gt(w_cnt_gt), .cnt_eq(w_cnt_eq), .cnt_lt(w_cnt_lt)
    );

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic m_full = 1'b0;

    // One handshake cycle on the main instance. Inputs change at negedge; the
    // transfer seen just before the next posedge is scored against the queue.
    task automatic drive_cycle(input logic v, input logic [1:0] a, input logic [1:0] b,
                               input logic ordy, input logic clr);
        exp_t e, got;
        logic m_rdy, acc;
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; out_ready = ordy; clear = clr;
        #1;
        m_rdy = !clr && (!m_full || ordy);
        acc   = v && m_rdy;
        vectors++;
        if (in_ready !== m_rdy) begin
            miscompares++;
            $display("FAIL in_ready: got %b want %b (a=%0d b=%0d)", in_ready, m_rdy, a, b);
        end
        vectors++;
        if (out_valid !== m_full) begin
            miscompares++;
            $display("FAIL out_valid: got %b want %b", out_valid, m_full);
        end
        if (out_valid && out_ready) begin
            got = '{out_gt, out_eq, out_lt, out_max, out_min};
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL result_unexpected: got %h want none", got);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL result: got gt/eq/lt=%b%b%b max=%0d min=%0d want %b%b%b max=%0d min=%0d",
                             got.gt, got.eq, got.lt, got.mx, got.mn, e.gt, e.eq, e.lt, e.mx, e.mn);
                end else begin
                    $display("xfer ok: gt/eq/lt=%b%b%b max=%0d min=%0d", got.gt, got.eq, got.lt, got.mx, got.mn);
                end
            end
        end
        if (acc) begin
            e.gt = (a > b); e.eq = (a == b); e.lt = (a < b);
            e.mx = (a > b) ? a : b;
            e.mn = (a > b) ? b : a;
            sb.push_back(e);
        end
        if (clr)                m_full = 1'b0;
        else if (acc)           m_full = 1'b1;
        else if (m_full && ordy) m_full = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        vectors++;
        if ({out_valid, out_gt, out_eq, out_lt} !== 4'b0 || out_max !== 2'd0 || out_min !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b flags=%b%b%b max=%0d min=%0d want all 0",
                     out_valid, out_gt, out_eq, out_lt, out_max, out_min);
        end
        vectors++;
        if (run_max !== 2'd0 || run_min !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_run: got max=%0d min=%0d want 0/3", run_max, run_min);
        end
        vectors++;
        if (cnt_gt !== 8'd0 || cnt_eq !== 8'd0 || cnt_lt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", cnt_gt, cnt_eq, cnt_lt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        $display("reset done");
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                drive_cycle(1'b1, 2'(a), 2'(b), 1'b1, 1'b0);
        drive_cycle(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
        vectors++;
        if (cnt_gt !== 8'd6 || cnt_eq !== 8'd4 || cnt_lt !== 8'd6) begin
            miscompares++;
            $display("FAIL sweep_cnt: got %0d/%0d/%0d want 6/4/6", cnt_gt, cnt_eq, cnt_lt);
        end
        vectors++;
        if (run_max !== 2'd3 || run_min !== 2'd0) begin
            miscompares++;
            $display("FAIL sweep_run: got max=%0d min=%0d want 3/0", run_max, run_min);
        end
    endtask

    task automatic test_backpressure();
        drive_cycle(1'b1, 2'd1, 2'd3, 1'b0, 1'b0);
        vectors++;
        if (in_ready !== 1'b0 || out_lt !== 1'b1 || out_max !== 2'd3 || out_min !== 2'd1) begin
            miscompares++;
            $display("FAIL bp_hold: got rdy=%b lt=%b max=%0d min=%0d want 0/1/3/1", in_ready, out_lt, out_max, out_min);
        end
        repeat (2) drive_cycle(1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
        vectors++;
        if (out_lt !== 1'b1 || out_gt !== 1'b0 || out_max !== 2'd3 || out_min !== 2'd1) begin
            miscompares++;
            $display("FAIL bp_stable: got gt=%b lt=%b max=%0d min=%0d want 0/1/3/1", out_gt, out_lt, out_max, out_min);
        end
        drive_cycle(1'b1, 2'd3, 2'd0, 1'b1, 1'b0);
        drive_cycle(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
        vectors++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: got pending=%0d out_valid=%b want 0/0", sb.size(), out_valid);
        end
    endtask

    task automatic test_clear();
        drive_cycle(1'b1, 2'd2, 2'd2, 1'b1, 1'b1);
        vectors++;
        if (cnt_gt !== 8'd0 || cnt_eq !== 8'd0 || cnt_lt !== 8'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_cnt: got %0d/%0d/%0d v=%b want 0/0/0 v=0", cnt_gt, cnt_eq, cnt_lt, out_valid);
        end
        vectors++;
        if (run_max !== 2'd0 || run_min !== 2'd3) begin
            miscompares++;
            $display("FAIL clear_run: got max=%0d min=%0d want 0/3", run_max, run_min);
        end
        drive_cycle(1'b1, 2'd2, 2'd2, 1'b1, 1'b0);
        vectors++;
        if (cnt_eq !== 8'd1 || out_eq !== 1'b1 || run_max !== 2'd2 || run_min !== 2'd2) begin
            miscompares++;
            $display("FAIL clear_after: got eq_cnt=%0d eq=%b run=%0d/%0d want 1/1/2/2", cnt_eq, out_eq, run_max, run_min);
        end
        drive_cycle(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        int want;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_in_valid = 1'b1; s_in_a = 2'd1; s_in_b = 2'd1; s_out_ready = 1'b1;
            @(posedge clk);
            #1;
            want = (i + 1 > 3) ? 3 : i + 1;
            vectors++;
            if (s_cnt_eq !== 2'(want)) begin
                miscompares++;
                $display("FAIL sat_cnt_eq: got %0d want %0d (pair %0d)", s_cnt_eq, want, i);
            end else begin
                $display("sat pair %0d: cnt_eq=%0d", i, s_cnt_eq);
            end
        end
        @(negedge clk) s_in_valid = 1'b0;
        vectors++;
        if (s_cnt_gt !== 2'd0 || s_cnt_lt !== 2'd0) begin
            miscompares++;
            $display("FAIL sat_others: got gt=%0d lt=%0d want 0/0", s_cnt_gt, s_cnt_lt);
        end
    endtask

    task automatic test_width4();
        @(negedge clk);
        w_in_valid = 1'b1; w_in_a = 4'hF; w_in_b = 4'h0; w_out_ready = 1'b1;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        vectors++;
        if (w_out_gt !== 1'b1 || w_out_max !== 4'd15 || w_out_min !== 4'd0) begin
            miscompares++;
            $display("FAIL w4_result: got gt=%b max=%0d min=%0d want 1/15/0", w_out_gt, w_out_max, w_out_min);
        end
        vectors++;
        if (w_run_max !== 4'd15 || w_run_min !== 4'd0 || w_cnt_gt !== 8'd1) begin
            miscompares++;
            $display("FAIL w4_stats: got run=%0d/%0d cnt_gt=%0d want 15/0/1", w_run_max, w_run_min, w_cnt_gt);
        end
    endtask

    task automatic test_midstream_reset();
        drive_cycle(1'b1, 2'd2, 2'd1, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_gt !== 1'b0 || cnt_gt !== 8'd0 || run_max !== 2'd0 || run_min !== 2'd3) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b gt=%b cnt_gt=%0d run=%0d/%0d want 0/0/0/0/3",
                     out_valid, out_gt, cnt_gt, run_max, run_min);
        end
        vectors++;
        if (w_run_max !== 4'd0 || s_cnt_eq !== 2'd0) begin
            miscompares++;
            $display("FAIL async_reset_aux: got w_run_max=%0d s_cnt_eq=%0d want 0/0", w_run_max, s_cnt_eq);
        end
        in_valid = 1'b0;
        sb.delete();
        m_full = 1'b0;
        @(negedge clk) rst = 1'b0;
        drive_cycle(1'b1, 2'd0, 2'd3, 1'b1, 1'b0);
        drive_cycle(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
        vectors++;
        if (cnt_lt !== 8'd1 || cnt_gt !== 8'd0) begin
            miscompares++;
            $display("FAIL post_reset_cnt: got lt=%0d gt=%0d want 1/0", cnt_lt, cnt_gt);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_backpressure();
        test_clear();
        test_saturation();
        test_width4();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
